// File: rtl/irrigation_pkg.sv
// Shared state encoding, default timing constants and counter-width helper
// for the irrigation sequencer.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEAD     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam int TICK_DIV_DEF           = 50_000_000;
  localparam int DEAD_TICKS_DEF         = 2;
  localparam int MIN_ON_TICKS_DEF       = 3;
  localparam int FILL_TIMEOUT_TICKS_DEF = 5;

  localparam int RUN_W = 3;

  // A counter that must hold the value n needs clog2(n)+1 bits.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int DEAD_W_DEF = $clog2(DEAD_TICKS_DEF) + 1;
  localparam int ON_W_DEF   = $clog2(MIN_ON_TICKS_DEF) + 1;
  localparam int FILL_W_DEF = $clog2(FILL_TIMEOUT_TICKS_DEF) + 1;

endpackage

// File: rtl/irrigation_sequencer_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and pulses tick for the one
// cycle in which the count wraps.
module tick_prescaler
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/irrigation_sequencer.sv
// Actuator sequencer: dead time and minimum on-time between sprinkler and
// dripper runs, fault shutdown, supervised tank filling and a run counter.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV           = TICK_DIV_DEF,
  parameter int DEAD_TICKS         = DEAD_TICKS_DEF,
  parameter int MIN_ON_TICKS       = MIN_ON_TICKS_DEF,
  parameter int FILL_TIMEOUT_TICKS = FILL_TIMEOUT_TICKS_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             irrigation_on,
  input  logic             splinker_mode_on,
  input  logic             conflicting_values,
  input  logic             water_supply_request,
  input  logic             high_water_level,
  output logic             splinker_bomb,
  output logic             dripper_valvule,
  output logic             water_supply_valvule,
  output logic             fill_timeout_alarm,
  output logic             fault_active,
  output logic [RUN_W-1:0] run_count
);

  localparam int DEAD_W = cnt_w(DEAD_TICKS);
  localparam int ON_W   = cnt_w(MIN_ON_TICKS);
  localparam int FILL_W = cnt_w(FILL_TIMEOUT_TICKS);

  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_TICKS);
  localparam logic [ON_W-1:0]   ON_MAX   = ON_W'(MIN_ON_TICKS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_TIMEOUT_TICKS);

  logic [4:0] in_p0;
  logic [4:0] in_p1;
  logic       s_irr, s_mode, s_conf, s_req, s_high;
  logic       tick;

  state_t            state, state_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;
  logic [ON_W-1:0]   on_cnt, on_nxt;
  logic              mode, mode_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;

  logic              bomb_d, drip_d, fault_d, valve_d;
  logic [FILL_W-1:0] fill_cnt;
  logic              fill_hit;

  // ---- stage p0/p1: two-flop input synchroniser ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_p0 <= '0;
      in_p1 <= '0;
    end else begin
      in_p0 <= {irrigation_on, splinker_mode_on, conflicting_values,
                water_supply_request, high_water_level};
      in_p1 <= in_p0;
    end
  end

  assign {s_irr, s_mode, s_conf, s_req, s_high} = in_p1;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // ---- sequencer state and counters ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dead_cnt <= '0;
      on_cnt   <= '0;
      mode     <= 1'b0;
      run_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      on_cnt   <= on_nxt;
      mode     <= mode_nxt;
      run_cnt  <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    on_nxt    = on_cnt;
    mode_nxt  = mode;
    run_nxt   = run_cnt;
    if (s_conf) begin
      state_nxt = FAULT;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_irr) begin
            state_nxt = DEAD;
            mode_nxt  = s_mode;
            dead_nxt  = '0;
          end
        end
        DEAD: begin
          if (!s_irr) begin
            state_nxt = IDLE;
          end else if (dead_cnt == DEAD_MAX) begin
            state_nxt = mode ? SPRINKLE : DRIP;
            on_nxt    = '0;
          end else if (tick) begin
            dead_nxt = dead_cnt + 1'b1;
          end
        end
        SPRINKLE, DRIP: begin
          // Minimum on-time gates every non-fault exit; irrigation_on=0 wins.
          if (on_cnt == ON_MAX) begin
            if (!s_irr) begin
              state_nxt = IDLE;
              run_nxt   = run_cnt + 1'b1;
            end else if (s_mode != mode) begin
              state_nxt = DEAD;
              mode_nxt  = s_mode;
              dead_nxt  = '0;
              run_nxt   = run_cnt + 1'b1;
            end
          end else if (tick) begin
            on_nxt = on_cnt + 1'b1;
          end
        end
        FAULT: begin
          if (tick) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- actuator decode ----
  assign fill_hit = (fill_cnt == FILL_MAX);

  always_comb begin
    bomb_d  = (state == SPRINKLE);
    drip_d  = (state == DRIP);
    fault_d = (state == FAULT);
    valve_d = s_req & ~s_high & ~fault_d & ~fill_timeout_alarm & ~fill_hit;
  end

  // ---- registered actuator outputs and fill supervision ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      fault_active         <= 1'b0;
      water_supply_valvule <= 1'b0;
      fill_timeout_alarm   <= 1'b0;
      fill_cnt             <= '0;
      run_count            <= '0;
    end else begin
      splinker_bomb        <= bomb_d;
      dripper_valvule      <= drip_d;
      fault_active         <= fault_d;
      water_supply_valvule <= valve_d;
      run_count            <= run_cnt;
      if (water_supply_valvule && fill_hit) begin
        fill_timeout_alarm <= 1'b1;
      end
      if (!water_supply_valvule) begin
        fill_cnt <= '0;
      end else if (tick && !fill_hit) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer: directed scenarios plus
// randomized stimulus against a cycle-level behavioural model.
module tb_irrigation_sequencer;

  localparam int TICK_DIV           = 4;
  localparam int DEAD_TICKS         = 2;
  localparam int MIN_ON_TICKS       = 3;
  localparam int FILL_TIMEOUT_TICKS = 5;

  localparam int M_IDLE  = 0;
  localparam int M_DEAD  = 1;
  localparam int M_SPR   = 2;
  localparam int M_DRIP  = 3;
  localparam int M_FAULT = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       irrigation_on = 1'b0;
  logic       splinker_mode_on = 1'b0;
  logic       conflicting_values = 1'b0;
  logic       water_supply_request = 1'b0;
  logic       high_water_level = 1'b0;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       fill_timeout_alarm;
  logic       fault_active;
  logic [2:0] run_count;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit last_tick = 1'b0;

  // behavioural model state
  int         m_pre, m_phase, m_dead, m_on, m_runs, m_fill;
  bit         m_mode, m_bomb, m_drip, m_valve, m_alarm, m_fault;
  logic [2:0] m_runq;
  logic [4:0] m_in1, m_in2;

  logic [7:0] exp_v, dut_v;
  assign exp_v = {m_bomb, m_drip, m_valve, m_alarm, m_fault, m_runq};
  assign dut_v = {splinker_bomb, dripper_valvule, water_supply_valvule,
                  fill_timeout_alarm, fault_active, run_count};

  irrigation_sequencer #(
    .TICK_DIV           (TICK_DIV),
    .DEAD_TICKS         (DEAD_TICKS),
    .MIN_ON_TICKS       (MIN_ON_TICKS),
    .FILL_TIMEOUT_TICKS (FILL_TIMEOUT_TICKS)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .irrigation_on        (irrigation_on),
    .splinker_mode_on     (splinker_mode_on),
    .conflicting_values   (conflicting_values),
    .water_supply_request (water_supply_request),
    .high_water_level     (high_water_level),
    .splinker_bomb        (splinker_bomb),
    .dripper_valvule      (dripper_valvule),
    .water_supply_valvule (water_supply_valvule),
    .fill_timeout_alarm   (fill_timeout_alarm),
    .fault_active         (fault_active),
    .run_count            (run_count)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_pre = 0; m_phase = M_IDLE; m_dead = 0; m_on = 0; m_runs = 0; m_fill = 0;
    m_mode = 0; m_bomb = 0; m_drip = 0; m_valve = 0; m_alarm = 0; m_fault = 0;
    m_runq = '0; m_in1 = '0; m_in2 = '0;
  endtask

  // One clock edge of the intended behaviour, using the inputs seen two edges ago.
  task automatic model_step();
    logic irr, md, cf, rq, hi;
    bit tk, nb, nd, nf, nv, na;
    int nfill;
    {irr, md, cf, rq, hi} = m_in2;
    tk = (m_pre == TICK_DIV - 1);
    nb = (m_phase == M_SPR);
    nd = (m_phase == M_DRIP);
    nf = (m_phase == M_FAULT);
    nv = rq && !hi && !nf && !m_alarm && (m_fill < FILL_TIMEOUT_TICKS);
    na = m_alarm || (m_valve && m_fill >= FILL_TIMEOUT_TICKS);
    if (!m_valve) nfill = 0;
    else if (tk && m_fill < FILL_TIMEOUT_TICKS) nfill = m_fill + 1;
    else nfill = m_fill;
    m_runq = 3'(m_runs);
    if (cf) begin
      m_phase = M_FAULT;
    end else begin
      case (m_phase)
        M_IDLE: if (irr) begin m_phase = M_DEAD; m_mode = md; m_dead = 0; end
        M_DEAD: begin
          if (!irr) m_phase = M_IDLE;
          else if (m_dead >= DEAD_TICKS) begin
            m_phase = m_mode ? M_SPR : M_DRIP;
            m_on = 0;
          end else if (tk) m_dead = m_dead + 1;
        end
        M_SPR, M_DRIP: begin
          if (m_on >= MIN_ON_TICKS) begin
            if (!irr) begin
              m_phase = M_IDLE; m_runs = (m_runs + 1) % 8;
            end else if (md != m_mode) begin
              m_phase = M_DEAD; m_mode = md; m_dead = 0; m_runs = (m_runs + 1) % 8;
            end
          end else if (tk) m_on = m_on + 1;
        end
        default: if (tk) m_phase = M_IDLE;
      endcase
    end
    m_bomb = nb; m_drip = nd; m_fault = nf; m_valve = nv; m_alarm = na; m_fill = nfill;
    m_in2 = m_in1;
    m_in1 = {irrigation_on, splinker_mode_on, conflicting_values,
             water_supply_request, high_water_level};
    m_pre = tk ? 0 : m_pre + 1;
  endtask

  task automatic clk_step();
    @(posedge clock);
    last_tick = (m_pre == TICK_DIV - 1);
    if (reset_n) begin
      model_step();
      edge_n++;
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    clk_step();
    clk_step();
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  // which: 0 = splinker_bomb, 1 = dripper_valvule
  task automatic wait_out(input int which, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim && !ok; c++) begin
      clk_step();
      ok = (which == 0) ? (splinker_bomb === 1'b1) : (dripper_valvule === 1'b1);
    end
  endtask

  task automatic test_reset();
    irrigation_on = 0; splinker_mode_on = 0; conflicting_values = 0;
    water_supply_request = 0; high_water_level = 0;
    apply_reset();
    n_cmp++;
    if (dut_v !== 8'h00) begin
      n_bad++; $display("FAIL reset_state: got %h expected 00", dut_v);
    end
    clk_step();
    n_cmp++;
    if (dut_v !== exp_v) begin
      n_bad++; $display("FAIL reset_idle: got %h expected %h", dut_v, exp_v);
    end
  endtask

  task automatic test_sprinkle_start();
    int rise = -1;
    irrigation_on = 1; splinker_mode_on = 1;
    apply_reset();
    for (int c = 1; c <= 40 && rise < 0; c++) begin
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL start_model: cycle %0d got %h expected %h", c, dut_v, exp_v);
      end
      n_cmp++;
      if (dripper_valvule !== 1'b0) begin
        n_bad++; $display("FAIL start_dripper: cycle %0d got %b expected 0", c, dripper_valvule);
      end
      if (splinker_bomb === 1'b1) rise = c;
    end
    n_cmp++;
    if (rise != 10) begin
      n_bad++; $display("FAIL start_rise_cycle: got %0d expected 10", rise);
    end
  endtask

  task automatic test_min_on_release();
    int fall = -1;
    for (int c = 0; c < 3; c++) clk_step();
    irrigation_on = 0;
    for (int c = 0; c < 40 && fall < 0; c++) begin
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL minon_model: edge %0d got %h expected %h", edge_n, dut_v, exp_v);
      end
      if (splinker_bomb === 1'b0) fall = edge_n;
    end
    n_cmp++;
    if (fall != 22) begin
      n_bad++; $display("FAIL minon_fall_edge: got %0d expected 22", fall);
    end
    n_cmp++;
    if (run_count !== 3'd1) begin
      n_bad++; $display("FAIL minon_run_count: got %0d expected 1", run_count);
    end
  endtask

  task automatic test_mode_switch();
    bit ok, fell;
    int gap_ticks = 0;
    irrigation_on = 1; splinker_mode_on = 1;
    wait_out(0, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL switch_bomb_on: got 0 expected 1");
    end
    for (int c = 0; c < 16; c++) clk_step();
    splinker_mode_on = 0;
    ok = 0; fell = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v || (splinker_bomb && dripper_valvule)) begin
        n_bad++; $display("FAIL switch_model: edge %0d got %h expected %h", edge_n, dut_v, exp_v);
      end
      if (!splinker_bomb && !dripper_valvule) begin
        fell = 1;
        if (last_tick) gap_ticks++;
      end
      ok = (dripper_valvule === 1'b1);
    end
    n_cmp++;
    if (!ok || !fell || gap_ticks < DEAD_TICKS) begin
      n_bad++; $display("FAIL switch_dead_ticks: got %0d expected >= %0d", gap_ticks, DEAD_TICKS);
    end
    n_cmp++;
    if (run_count !== 3'd2) begin
      n_bad++; $display("FAIL switch_run_count: got %0d expected 2", run_count);
    end
  endtask

  task automatic test_fault();
    int lat = -1;
    int rel = -1;
    clk_step(); clk_step();
    conflicting_values = 1;
    for (int c = 1; c <= 4 && lat < 0; c++) begin
      clk_step();
      if (fault_active === 1'b1 && dripper_valvule === 1'b0) lat = c;
    end
    n_cmp++;
    if (lat < 0) begin
      n_bad++; $display("FAIL fault_entry: got fault=%b drip=%b expected 1/0", fault_active, dripper_valvule);
    end
    for (int c = 0; c < 5; c++) begin
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL fault_hold: got %h expected %h", dut_v, exp_v);
      end
    end
    conflicting_values = 0; irrigation_on = 0;
    for (int c = 1; c <= 20 && rel < 0; c++) begin
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL fault_release_model: got %h expected %h", dut_v, exp_v);
      end
      if (fault_active === 1'b0) rel = c;
    end
    n_cmp++;
    if (rel < 0 || rel > TICK_DIV + 3) begin
      n_bad++; $display("FAIL fault_release_latency: got %0d expected <= %0d", rel, TICK_DIV + 3);
    end
    n_cmp++;
    if (run_count !== 3'd2) begin
      n_bad++; $display("FAIL fault_run_count: got %0d expected 2", run_count);
    end
  endtask

  task automatic test_fill_timeout();
    int ticks_open = 0;
    bit opened = 0, closed = 0, vb;
    water_supply_request = 1; high_water_level = 0;
    for (int c = 0; c < 60 && !closed; c++) begin
      vb = water_supply_valvule;
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL fill_model: got %h expected %h", dut_v, exp_v);
      end
      if (vb && last_tick) ticks_open++;
      if (water_supply_valvule) opened = 1;
      else if (opened) closed = 1;
    end
    n_cmp++;
    if (!closed || ticks_open != FILL_TIMEOUT_TICKS) begin
      n_bad++; $display("FAIL fill_open_ticks: got %0d expected %0d", ticks_open, FILL_TIMEOUT_TICKS);
    end
    n_cmp++;
    if (fill_timeout_alarm !== 1'b1) begin
      n_bad++; $display("FAIL fill_alarm_set: got %b expected 1", fill_timeout_alarm);
    end
    water_supply_request = 0;
    for (int c = 0; c < 10; c++) clk_step();
    n_cmp++;
    if (fill_timeout_alarm !== 1'b1 || water_supply_valvule !== 1'b0) begin
      n_bad++; $display("FAIL fill_alarm_sticky: got alarm=%b valve=%b expected 1/0",
                        fill_timeout_alarm, water_supply_valvule);
    end
    apply_reset();
    n_cmp++;
    if (fill_timeout_alarm !== 1'b0) begin
      n_bad++; $display("FAIL fill_alarm_clear: got %b expected 0", fill_timeout_alarm);
    end
  endtask

  task automatic test_reset_mid_sprinkle();
    bit ok;
    irrigation_on = 1; splinker_mode_on = 1;
    wait_out(0, 40, ok);
    for (int c = 0; c < 16; c++) clk_step();
    splinker_mode_on = 0;
    wait_out(1, 60, ok);
    for (int c = 0; c < 16; c++) clk_step();
    splinker_mode_on = 1;
    wait_out(0, 60, ok);
    clk_step();
    n_cmp++;
    if (!ok || dut_v !== exp_v || run_count !== 3'd2) begin
      n_bad++; $display("FAIL midrst_prepare: got %h expected %h", dut_v, exp_v);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_v !== 8'h00) begin
      n_bad++; $display("FAIL midrst_async: got %h expected 00", dut_v);
    end
    model_reset();
    clk_step();
    reset_n = 1'b1;
    edge_n = 0;
    irrigation_on = 0;
    for (int c = 0; c < 4; c++) clk_step();
    n_cmp++;
    if (dut_v !== exp_v || run_count !== 3'd0) begin
      n_bad++; $display("FAIL midrst_after: got %h expected %h", dut_v, exp_v);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) apply_reset();
      if (hold == 0) begin
        irrigation_on        = ($urandom_range(0, 3) != 0);
        splinker_mode_on     = $urandom_range(0, 1);
        conflicting_values   = ($urandom_range(0, 24) == 0);
        water_supply_request = $urandom_range(0, 1);
        high_water_level     = ($urandom_range(0, 2) == 0);
        hold = conflicting_values ? $urandom_range(1, 6) : $urandom_range(1, 40);
      end
      hold--;
      clk_step();
      n_cmp++;
      if (dut_v !== exp_v || (splinker_bomb && dripper_valvule)) begin
        n_bad++; $display("FAIL random: cycle %0d got %h expected %h", c, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sprinkle_start();
    test_min_on_release();
    test_mode_switch();
    test_fault();
    test_fill_timeout();
    test_reset_mid_sprinkle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
